// File: rtl/multicycle_controller_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS controller. It holds the FSM
// state type, the MIPS opcode/funct/rt constants, the ALUControl encodings,
// the MemRead/MemWrite size codes, the PCSource and ALUSrcB select codes, and
// small helpers that classify memory opcodes.
// No ports (package).
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MUL_WAIT,
        S_MEM_ADDR,
        S_MEM_ACC,
        S_WB,
        S_BRANCH,
        S_JUMP
    } state_t;

    // Primary opcodes (Instruction[31:26])
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_SLTI     = 6'h0a;
    localparam logic [5:0] OP_ANDI     = 6'h0c;
    localparam logic [5:0] OP_ORI      = 6'h0d;
    localparam logic [5:0] OP_XORI     = 6'h0e;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1c;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2b;

    // R-type funct codes (Instruction[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;

    // SPECIAL2 funct for mul
    localparam logic [5:0] FN_MUL = 6'h02;

    // REGIMM rt selectors
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    // ALUControl encodings
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_MUL  = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_AND  = 5'b00110;
    localparam logic [4:0] ALU_OR   = 5'b00111;
    localparam logic [4:0] ALU_XOR  = 5'b01000;
    localparam logic [4:0] ALU_NOR  = 5'b01101;
    localparam logic [4:0] ALU_SLT  = 5'b01110;

    // MemRead / MemWrite size codes
    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_WORD = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam logic [1:0] MEM_BYTE = 2'b11;

    // PCSource selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    function automatic logic isLoad(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    endfunction

    function automatic logic isStore(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Access size shared by the load and store of the same width
    function automatic logic [1:0] memSize(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return MEM_WORD;
            OP_LH, OP_SH: return MEM_HALF;
            OP_LB, OP_SB: return MEM_BYTE;
            default:      return MEM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// ----------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the instruction/handshake inputs and every datapath control line of
// the multi-cycle controller.
//   slave  : controller side (takes Instruction, MemReady, BranchCond and
//            drives all control outputs)
//   master : datapath/environment side (the mirror image)
// ----------------------------------------------------------------------------
interface multicycle_controller_if #(
    parameter int ALU_CTRL_W = 5
) ();

    logic [31:0]           Instruction;
    logic                  MemReady;
    logic                  BranchCond;

    logic                  PCWrite;
    logic                  IRWrite;
    logic                  IorD;
    logic                  RegWrite;
    logic                  RegDst;
    logic                  MemToReg;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic                  ShiftControl;
    logic [1:0]            MemRead;
    logic [1:0]            MemWrite;
    logic [1:0]            PCSource;
    logic                  Jal;
    logic                  MulStart;
    logic                  IllegalOp;
    logic                  Busy;

    modport master (
        output Instruction, MemReady, BranchCond,
        input  PCWrite, IRWrite, IorD, RegWrite, RegDst, MemToReg, ALUSrcA,
               ALUSrcB, ALUControl, ShiftControl, MemRead, MemWrite, PCSource,
               Jal, MulStart, IllegalOp, Busy
    );

    modport slave (
        input  Instruction, MemReady, BranchCond,
        output PCWrite, IRWrite, IorD, RegWrite, RegDst, MemToReg, ALUSrcA,
               ALUSrcB, ALUControl, ShiftControl, MemRead, MemWrite, PCSource,
               Jal, MulStart, IllegalOp, Busy
    );

endinterface

// File: rtl/multicycle_controller_alu_decode.sv
// ----------------------------------------------------------------------------
// mc_alu_decode
// Purely combinational map from opcode/funct/rt to the ALU operation. Used by
// the EXEC state (R-type, mul, immediates) and the BRANCH state (compare op).
//   i_opcode       : Instruction[31:26]
//   i_funct        : Instruction[5:0]
//   i_rt           : Instruction[20:16], selects bltz/bgez under REGIMM
//   o_aluControl   : ALU operation code
//   o_shiftControl : shamt replaces rs (sll/srl)
//   o_illegal      : opcode/funct/rt combination has no ALU meaning
// ----------------------------------------------------------------------------
module mc_alu_decode
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 5
) (
    input  logic [5:0]            i_opcode,
    input  logic [5:0]            i_funct,
    input  logic [4:0]            i_rt,
    output logic [ALU_CTRL_W-1:0] o_aluControl,
    output logic                  o_shiftControl,
    output logic                  o_illegal
);

    logic [4:0] w_code;
    logic       w_shift;
    logic       w_illegal;

    // Unsupported combinations report ALU_NONE so a bad instruction never
    // requests a real ALU operation. Branches compare with sub (equality)
    // or slt (sign tests against zero).
    always_comb begin
        w_code    = ALU_NONE;
        w_shift   = 1'b0;
        w_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  w_code = ALU_ADD;
                    FN_SUB:  w_code = ALU_SUB;
                    FN_AND:  w_code = ALU_AND;
                    FN_OR:   w_code = ALU_OR;
                    FN_XOR:  w_code = ALU_XOR;
                    FN_NOR:  w_code = ALU_NOR;
                    FN_SLT:  w_code = ALU_SLT;
                    FN_SLL: begin
                        w_code  = ALU_SLL;
                        w_shift = 1'b1;
                    end
                    FN_SRL: begin
                        w_code  = ALU_SRL;
                        w_shift = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_SPECIAL2: begin
                if (i_funct == FN_MUL) begin
                    w_code = ALU_MUL;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_ADDI:         w_code = ALU_ADD;
            OP_ANDI:         w_code = ALU_AND;
            OP_ORI:          w_code = ALU_OR;
            OP_XORI:         w_code = ALU_XOR;
            OP_SLTI:         w_code = ALU_SLT;
            OP_BEQ, OP_BNE:  w_code = ALU_SUB;
            OP_BLEZ, OP_BGTZ: w_code = ALU_SLT;
            OP_REGIMM: begin
                if ((i_rt == RT_BLTZ) || (i_rt == RT_BGEZ)) begin
                    w_code = ALU_SLT;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default:         w_illegal = 1'b1;
        endcase
    end

    assign o_aluControl   = ALU_CTRL_W'(w_code);
    assign o_shiftControl = w_shift;
    assign o_illegal      = w_illegal;

endmodule

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
// Multi-cycle MIPS control FSM. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB (plus BRANCH, JUMP and a multiplier wait), stalls
// on the memory handshake and drives the datapath control lines per state.
//   Clk     : system clock, rising edge
//   Rst     : asynchronous active-low reset
//   ctrlBus : slave side of multicycle_controller_if (Instruction, MemReady,
//             BranchCond in; all datapath controls, MulStart, IllegalOp and
//             Busy out)
// ----------------------------------------------------------------------------
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int ALU_CTRL_W  = 5,
    parameter int CNT_W       = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    multicycle_controller_if.slave ctrlBus
);

    state_t                r_state;
    state_t                w_nextState;
    logic [CNT_W-1:0]      r_waitCnt;

    logic [5:0]            w_opcode;
    logic [5:0]            w_funct;
    logic [4:0]            w_rt;
    logic [ALU_CTRL_W-1:0] w_aluControl;
    logic                  w_shiftControl;
    logic                  w_aluIllegal;

    logic                  w_isRtype;
    logic                  w_isMul;
    logic                  w_isJr;
    logic                  w_isImm;
    logic                  w_isLoad;
    logic                  w_isStore;
    logic                  w_isCmpBranch;
    logic                  w_unused;

    assign w_opcode = ctrlBus.Instruction[31:26];
    assign w_funct  = ctrlBus.Instruction[5:0];
    assign w_rt     = ctrlBus.Instruction[20:16];

    // Register numbers and immediates belong to the datapath, not to us
    assign w_unused = ^{ctrlBus.Instruction[25:21], ctrlBus.Instruction[15:6]};

    assign w_isRtype     = (w_opcode == OP_RTYPE);
    assign w_isMul       = (w_opcode == OP_SPECIAL2);
    assign w_isJr        = w_isRtype && (w_funct == FN_JR);
    assign w_isImm       = (w_opcode == OP_ADDI) || (w_opcode == OP_ANDI) ||
                           (w_opcode == OP_ORI)  || (w_opcode == OP_XORI) ||
                           (w_opcode == OP_SLTI);
    assign w_isLoad      = isLoad(w_opcode);
    assign w_isStore     = isStore(w_opcode);
    assign w_isCmpBranch = (w_opcode == OP_BEQ)  || (w_opcode == OP_BNE) ||
                           (w_opcode == OP_BLEZ) || (w_opcode == OP_BGTZ);

    mc_alu_decode #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_aluDecode (
        .i_opcode       (w_opcode),
        .i_funct        (w_funct),
        .i_rt           (w_rt),
        .o_aluControl   (w_aluControl),
        .o_shiftControl (w_shiftControl),
        .o_illegal      (w_aluIllegal)
    );

    // State register; reset abandons whatever instruction was in flight
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Multiplier wait counter: loaded with MUL_LATENCY-1 as mul leaves EXEC
    // so MUL_WAIT lasts exactly MUL_LATENCY cycles (exit when it reads 0)
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_waitCnt <= '0;
        end else if ((r_state == S_EXEC) && w_isMul && !w_aluIllegal) begin
            r_waitCnt <= CNT_W'(MUL_LATENCY - 1);
        end else if ((r_state == S_MUL_WAIT) && (r_waitCnt != '0)) begin
            r_waitCnt <= r_waitCnt - CNT_W'(1);
        end
    end

    // Next-state and Moore-per-state outputs; everything defaults to 0 so a
    // state only mentions the lines it actually drives
    always_comb begin
        w_nextState          = r_state;
        ctrlBus.PCWrite      = 1'b0;
        ctrlBus.IRWrite      = 1'b0;
        ctrlBus.IorD         = 1'b0;
        ctrlBus.RegWrite     = 1'b0;
        ctrlBus.RegDst       = 1'b0;
        ctrlBus.MemToReg     = 1'b0;
        ctrlBus.ALUSrcA      = 1'b0;
        ctrlBus.ALUSrcB      = SRCB_RT;
        ctrlBus.ALUControl   = '0;
        ctrlBus.ShiftControl = 1'b0;
        ctrlBus.MemRead      = MEM_NONE;
        ctrlBus.MemWrite     = MEM_NONE;
        ctrlBus.PCSource     = PCSRC_ALU;
        ctrlBus.Jal          = 1'b0;
        ctrlBus.MulStart     = 1'b0;
        ctrlBus.IllegalOp    = 1'b0;
        ctrlBus.Busy         = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                w_nextState = S_FETCH;
            end

            // PC+4 is computed every fetch cycle but only committed together
            // with the IR load once memory answers
            S_FETCH: begin
                ctrlBus.MemRead    = MEM_WORD;
                ctrlBus.ALUSrcB    = SRCB_FOUR;
                ctrlBus.ALUControl = ALU_CTRL_W'(ALU_ADD);
                if (ctrlBus.MemReady) begin
                    ctrlBus.IRWrite = 1'b1;
                    ctrlBus.PCWrite = 1'b1;
                    w_nextState     = S_DECODE;
                end
            end

            // Branch target PC+4+(imm<<2) lands in ALUOut while we route
            S_DECODE: begin
                ctrlBus.ALUSrcB    = SRCB_IMMSH2;
                ctrlBus.ALUControl = ALU_CTRL_W'(ALU_ADD);
                if (w_isJr) begin
                    w_nextState = S_JUMP;
                end else if (w_isRtype || w_isMul || w_isImm) begin
                    w_nextState = S_EXEC;
                end else if (w_isLoad || w_isStore) begin
                    w_nextState = S_MEM_ADDR;
                end else if (w_isCmpBranch) begin
                    w_nextState = S_BRANCH;
                end else if ((w_opcode == OP_REGIMM) && !w_aluIllegal) begin
                    w_nextState = S_BRANCH;
                end else if ((w_opcode == OP_J) || (w_opcode == OP_JAL)) begin
                    w_nextState = S_JUMP;
                end else begin
                    ctrlBus.IllegalOp = 1'b1;
                    w_nextState       = S_FETCH;
                end
            end

            S_EXEC: begin
                ctrlBus.ALUSrcA      = 1'b1;
                ctrlBus.ALUSrcB      = (w_isRtype || w_isMul) ? SRCB_RT : SRCB_IMM;
                ctrlBus.ALUControl   = w_aluControl;
                ctrlBus.ShiftControl = w_shiftControl;
                if (w_aluIllegal) begin
                    ctrlBus.IllegalOp = 1'b1;
                    w_nextState       = S_FETCH;
                end else if (w_isMul) begin
                    ctrlBus.MulStart = 1'b1;
                    w_nextState      = S_MUL_WAIT;
                end else begin
                    w_nextState = S_WB;
                end
            end

            S_MUL_WAIT: begin
                if (r_waitCnt == '0) begin
                    w_nextState = S_WB;
                end
            end

            S_MEM_ADDR: begin
                ctrlBus.ALUSrcA    = 1'b1;
                ctrlBus.ALUSrcB    = SRCB_IMM;
                ctrlBus.ALUControl = ALU_CTRL_W'(ALU_ADD);
                w_nextState        = S_MEM_ACC;
            end

            // Request is held steady until memory signals completion
            S_MEM_ACC: begin
                ctrlBus.IorD = 1'b1;
                if (w_isLoad) begin
                    ctrlBus.MemRead = memSize(w_opcode);
                end else begin
                    ctrlBus.MemWrite = memSize(w_opcode);
                end
                if (ctrlBus.MemReady) begin
                    w_nextState = w_isLoad ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                ctrlBus.RegWrite = 1'b1;
                ctrlBus.RegDst   = w_isRtype || w_isMul;
                ctrlBus.MemToReg = !w_isLoad;
                w_nextState      = S_FETCH;
            end

            S_BRANCH: begin
                ctrlBus.ALUSrcA    = 1'b1;
                ctrlBus.ALUSrcB    = SRCB_RT;
                ctrlBus.ALUControl = w_aluControl;
                ctrlBus.PCSource   = PCSRC_ALUOUT;
                ctrlBus.PCWrite    = ctrlBus.BranchCond;
                w_nextState        = S_FETCH;
            end

            S_JUMP: begin
                ctrlBus.PCWrite  = 1'b1;
                ctrlBus.PCSource = w_isJr ? PCSRC_RS : PCSRC_JUMP;
                if (w_opcode == OP_JAL) begin
                    ctrlBus.Jal      = 1'b1;
                    ctrlBus.RegWrite = 1'b1;
                end
                w_nextState = S_FETCH;
            end

            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
// Builds the expected cycle-by-cycle control trace of each instruction from
// its class and the chosen memory/branch timing, then replays that trace
// against the controller and compares every output on every cycle.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int MUL_LAT = 4;

    // Instruction classes used by the reference model
    localparam int C_ALU_R   = 0;
    localparam int C_MUL     = 1;
    localparam int C_ALU_I   = 2;
    localparam int C_LOAD    = 3;
    localparam int C_STORE   = 4;
    localparam int C_BRANCH  = 5;
    localparam int C_J       = 6;
    localparam int C_JAL     = 7;
    localparam int C_JR      = 8;
    localparam int C_ILLEGAL = 9;

    // Phase tags, only used to make FAIL lines readable
    localparam int P_RESET  = 0;
    localparam int P_IDLE   = 1;
    localparam int P_FETCH  = 2;
    localparam int P_DECODE = 3;
    localparam int P_EXEC   = 4;
    localparam int P_MULW   = 5;
    localparam int P_MADDR  = 6;
    localparam int P_MACC   = 7;
    localparam int P_WB     = 8;
    localparam int P_BRANCH = 9;
    localparam int P_JUMP   = 10;

    typedef struct packed {
        logic       pcWrite;
        logic       irWrite;
        logic       iorD;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [4:0] aluControl;
        logic       shiftControl;
        logic [1:0] memRead;
        logic [1:0] memWrite;
        logic [1:0] pcSource;
        logic       jal;
        logic       mulStart;
        logic       illegalOp;
        logic       busy;
    } ctrl_t;

    typedef struct {
        logic        rst;
        logic        memReady;
        logic        branchCond;
        logic [31:0] instr;
        ctrl_t       exp;
        int          phase;
    } step_t;

    logic  Clk = 1'b0;
    logic  Rst = 1'b0;
    int    testsRun    = 0;
    int    testsFailed = 0;
    int    cycleNo     = 0;
    step_t script[$];

    multicycle_controller_if #(.ALU_CTRL_W(5)) bus ();

    multicycle_controller #(
        .MUL_LATENCY (MUL_LAT),
        .ALU_CTRL_W  (5),
        .CNT_W       (4)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .ctrlBus (bus.slave)
    );

    always #5 Clk = ~Clk;

    function automatic string phaseName(input int p);
        case (p)
            P_RESET:  return "reset";
            P_IDLE:   return "idle";
            P_FETCH:  return "fetch";
            P_DECODE: return "decode";
            P_EXEC:   return "exec";
            P_MULW:   return "mulwait";
            P_MADDR:  return "memaddr";
            P_MACC:   return "memacc";
            P_WB:     return "writeback";
            P_BRANCH: return "branch";
            P_JUMP:   return "jump";
            default:  return "unknown";
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ctrl_t zeroCtrl();
        return '0;
    endfunction

    function automatic ctrl_t busyCtrl();
        ctrl_t c;
        c = '0;
        c.busy = 1'b1;
        return c;
    endfunction

    // Which kind of instruction this word is, straight from the opcode map
    function automatic int classify(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        op = w[31:26];
        fn = w[5:0];
        rt = w[20:16];
        case (op)
            6'h00: return (fn == 6'h08) ? C_JR : C_ALU_R;
            6'h1c: return C_MUL;
            6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e: return C_ALU_I;
            6'h20, 6'h21, 6'h23: return C_LOAD;
            6'h28, 6'h29, 6'h2b: return C_STORE;
            6'h04, 6'h05, 6'h06, 6'h07: return C_BRANCH;
            6'h01: return (rt == 5'd0 || rt == 5'd1) ? C_BRANCH : C_ILLEGAL;
            6'h02: return C_J;
            6'h03: return C_JAL;
            default: return C_ILLEGAL;
        endcase
    endfunction

    // ALU operation an EXEC-class instruction asks for
    function automatic void execInfo(input logic [31:0] w, output logic legal,
                                     output logic [4:0] code, output logic shift);
        logic [5:0] op;
        logic [5:0] fn;
        op    = w[31:26];
        fn    = w[5:0];
        legal = 1'b1;
        shift = 1'b0;
        code  = 5'd0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: code = 5'b00001;
                6'h22: code = 5'b00010;
                6'h24: code = 5'b00110;
                6'h25: code = 5'b00111;
                6'h26: code = 5'b01000;
                6'h27: code = 5'b01101;
                6'h2a: code = 5'b01110;
                6'h00: begin code = 5'b00100; shift = 1'b1; end
                6'h02: begin code = 5'b00101; shift = 1'b1; end
                default: legal = 1'b0;
            endcase
        end else if (op == 6'h1c) begin
            if (fn == 6'h02) code = 5'b00011;
            else             legal = 1'b0;
        end else begin
            case (op)
                6'h08: code = 5'b00001;
                6'h0c: code = 5'b00110;
                6'h0d: code = 5'b00111;
                6'h0e: code = 5'b01000;
                6'h0a: code = 5'b01110;
                default: legal = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [1:0] sizeOf(input logic [5:0] op);
        case (op)
            6'h23, 6'h2b: return 2'b01;
            6'h21, 6'h29: return 2'b10;
            default:      return 2'b11;
        endcase
    endfunction

    task automatic pushStep(input logic rst, input logic mr, input logic bc,
                            input logic [31:0] w, input ctrl_t e, input int ph);
        step_t s;
        s.rst        = rst;
        s.memReady   = mr;
        s.branchCond = bc;
        s.instr      = w;
        s.exp        = e;
        s.phase      = ph;
        script.push_back(s);
    endtask

    // n cycles held in reset, then one IDLE cycle after release
    task automatic pushReset(input int n, input logic mrHigh);
        for (int i = 0; i < n; i++) begin
            pushStep(1'b0, mrHigh | rbit(), rbit(), 32'h0, zeroCtrl(), P_RESET);
        end
        pushStep(1'b1, mrHigh | rbit(), rbit(), 32'h0, zeroCtrl(), P_IDLE);
    endtask

    // Expected trace of one instruction. bcSel: 0/1 force BranchCond, 2 random
    task automatic buildInstr(input logic [31:0] w, input int fetchWait,
                              input int memWait, input int bcSel);
        ctrl_t      e;
        int         cls;
        logic       legal;
        logic       shift;
        logic [4:0] code;
        logic       bc;
        logic [5:0] op;
        op  = w[31:26];
        cls = classify(w);

        e = busyCtrl();
        e.memRead    = 2'b01;
        e.aluSrcB    = 2'b01;
        e.aluControl = 5'b00001;
        for (int i = 0; i < fetchWait; i++) pushStep(1'b1, 1'b0, rbit(), w, e, P_FETCH);
        e.pcWrite = 1'b1;
        e.irWrite = 1'b1;
        pushStep(1'b1, 1'b1, rbit(), w, e, P_FETCH);

        e = busyCtrl();
        e.aluSrcB    = 2'b11;
        e.aluControl = 5'b00001;
        e.illegalOp  = (cls == C_ILLEGAL);
        pushStep(1'b1, rbit(), rbit(), w, e, P_DECODE);
        if (cls == C_ILLEGAL) return;

        if (cls == C_ALU_R || cls == C_MUL || cls == C_ALU_I) begin
            execInfo(w, legal, code, shift);
            e = busyCtrl();
            e.aluSrcA      = 1'b1;
            e.aluSrcB      = (cls == C_ALU_I) ? 2'b10 : 2'b00;
            e.aluControl   = legal ? code : 5'd0;
            e.shiftControl = legal & shift;
            e.illegalOp    = !legal;
            e.mulStart     = legal && (cls == C_MUL);
            pushStep(1'b1, rbit(), rbit(), w, e, P_EXEC);
            if (!legal) return;
            if (cls == C_MUL) begin
                for (int i = 0; i < MUL_LAT; i++) pushStep(1'b1, rbit(), rbit(), w, busyCtrl(), P_MULW);
            end
            e = busyCtrl();
            e.regWrite = 1'b1;
            e.regDst   = (cls != C_ALU_I);
            e.memToReg = 1'b1;
            pushStep(1'b1, rbit(), rbit(), w, e, P_WB);
        end else if (cls == C_LOAD || cls == C_STORE) begin
            e = busyCtrl();
            e.aluSrcA    = 1'b1;
            e.aluSrcB    = 2'b10;
            e.aluControl = 5'b00001;
            pushStep(1'b1, rbit(), rbit(), w, e, P_MADDR);
            e = busyCtrl();
            e.iorD = 1'b1;
            if (cls == C_LOAD) e.memRead  = sizeOf(op);
            else               e.memWrite = sizeOf(op);
            for (int i = 0; i < memWait; i++) pushStep(1'b1, 1'b0, rbit(), w, e, P_MACC);
            pushStep(1'b1, 1'b1, rbit(), w, e, P_MACC);
            if (cls == C_LOAD) begin
                e = busyCtrl();
                e.regWrite = 1'b1;
                pushStep(1'b1, rbit(), rbit(), w, e, P_WB);
            end
        end else if (cls == C_BRANCH) begin
            bc = (bcSel == 2) ? rbit() : (bcSel == 1);
            e = busyCtrl();
            e.aluSrcA    = 1'b1;
            e.aluControl = (op == 6'h04 || op == 6'h05) ? 5'b00010 : 5'b01110;
            e.pcSource   = 2'b01;
            e.pcWrite    = bc;
            pushStep(1'b1, rbit(), bc, w, e, P_BRANCH);
        end else begin
            e = busyCtrl();
            e.pcWrite  = 1'b1;
            e.pcSource = (cls == C_JR) ? 2'b11 : 2'b10;
            e.jal      = (cls == C_JAL);
            e.regWrite = (cls == C_JAL);
            pushStep(1'b1, rbit(), rbit(), w, e, P_JUMP);
        end
    endtask

    // Mostly legal instructions with random fields, some fully random words
    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        logic [5:0]  op;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 23);
        case (k)
            0, 1, 2, 3: op = 6'h00;
            4:  op = 6'h1c;  5:  op = 6'h08;  6:  op = 6'h0a;  7:  op = 6'h0c;
            8:  op = 6'h0d;  9:  op = 6'h0e;  10: op = 6'h20;  11: op = 6'h21;
            12: op = 6'h23;  13: op = 6'h28;  14: op = 6'h29;  15: op = 6'h2b;
            16: op = 6'h04;  17: op = 6'h05;  18: op = 6'h06;  19: op = 6'h07;
            20: op = 6'h01;  21: op = 6'h02;  22: op = 6'h03;
            default: op = w[31:26];
        endcase
        w[31:26] = op;
        if (op == 6'h00) begin
            case ($urandom_range(0, 10))
                0: w[5:0] = 6'h20;  1: w[5:0] = 6'h22;  2: w[5:0] = 6'h24;
                3: w[5:0] = 6'h25;  4: w[5:0] = 6'h26;  5: w[5:0] = 6'h27;
                6: w[5:0] = 6'h2a;  7: w[5:0] = 6'h00;  8: w[5:0] = 6'h02;
                9: w[5:0] = 6'h08;
                default: ;
            endcase
        end
        if (op == 6'h1c && $urandom_range(0, 3) != 0) w[5:0] = 6'h02;
        if (op == 6'h01 && $urandom_range(0, 3) != 0) w[20:16] = {4'b0, rbit()};
        return w;
    endfunction

    function automatic ctrl_t sampleDut();
        ctrl_t c;
        c.pcWrite      = bus.PCWrite;
        c.irWrite      = bus.IRWrite;
        c.iorD         = bus.IorD;
        c.regWrite     = bus.RegWrite;
        c.regDst       = bus.RegDst;
        c.memToReg     = bus.MemToReg;
        c.aluSrcA      = bus.ALUSrcA;
        c.aluSrcB      = bus.ALUSrcB;
        c.aluControl   = bus.ALUControl;
        c.shiftControl = bus.ShiftControl;
        c.memRead      = bus.MemRead;
        c.memWrite     = bus.MemWrite;
        c.pcSource     = bus.PCSource;
        c.jal          = bus.Jal;
        c.mulStart     = bus.MulStart;
        c.illegalOp    = bus.IllegalOp;
        c.busy         = bus.Busy;
        return c;
    endfunction

    task automatic checkOutput(input step_t s);
        ctrl_t act;
        act = sampleDut();
        testsRun++;
        if (act !== s.exp) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d instr %h: got %h expected %h",
                     phaseName(s.phase), cycleNo, s.instr, act, s.exp);
        end
    endtask

    // Pins the trace builder itself to hand-computed facts
    task automatic checkModel(input string name, input int got, input int want);
        testsRun++;
        if (got != want) begin
            testsFailed++;
            $display("[TB] FAIL model %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Replays the trace: inputs change on the falling edge, outputs are
    // compared 1 time unit later, well clear of the rising edge
    task automatic applyStimulus();
        step_t s;
        while (script.size() > 0) begin
            s = script.pop_front();
            @(negedge Clk);
            Rst             = s.rst;
            bus.MemReady    = s.memReady;
            bus.BranchCond  = s.branchCond;
            bus.Instruction = s.instr;
            #1;
            checkOutput(s);
            cycleNo++;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int cnt;
        Rst             = 1'b0;
        bus.Instruction = 32'h0;
        bus.MemReady    = 1'b0;
        bus.BranchCond  = 1'b0;

        pushReset(3, 1'b0);

        // add $3,$1,$2 with memory always ready
        base = script.size();
        buildInstr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 0, 0, 2);
        checkModel("add length", script.size() - base, 4);
        checkModel("add exec alu", int'(script[base + 2].exp.aluControl), 1);
        checkModel("add wb regdst", int'(script[base + 3].exp.regDst), 1);

        // lw $4,8($1) with 3 not-ready cycles in the memory access
        base = script.size();
        buildInstr({6'h23, 5'd1, 5'd4, 16'd8}, 0, 3, 2);
        checkModel("lw length", script.size() - base, 8);
        cnt = 0;
        for (int i = base; i < script.size(); i++) begin
            if (script[i].exp.iorD && script[i].exp.memRead == 2'b01) cnt++;
        end
        checkModel("lw memacc cycles", cnt, 4);
        checkModel("lw wb memtoreg", int'(script[script.size() - 1].exp.memToReg), 0);

        // mul $5,$1,$2
        base = script.size();
        buildInstr({6'h1c, 5'd1, 5'd2, 5'd5, 5'd0, 6'h02}, 0, 0, 2);
        checkModel("mul length", script.size() - base, 8);
        checkModel("mul start pulse", int'(script[base + 2].exp.mulStart), 1);

        // beq taken, bne not taken
        buildInstr({6'h04, 5'd1, 5'd2, 16'h0010}, 0, 0, 1);
        buildInstr({6'h05, 5'd1, 5'd2, 16'h0010}, 1, 0, 0);

        // jr $31, jal 0x100
        buildInstr({6'h00, 5'd31, 15'd0, 6'h08}, 0, 0, 2);
        base = script.size();
        buildInstr({6'h03, 26'h40}, 0, 0, 2);
        checkModel("jal pcsource", int'(script[script.size() - 1].exp.pcSource), 2);

        // unsupported opcode stops after DECODE
        base = script.size();
        buildInstr({6'h3f, 26'h0123456}, 0, 0, 2);
        checkModel("illegal length", script.size() - base, 2);

        // sw abandoned by reset in the middle of its memory access
        buildInstr({6'h2b, 5'd1, 5'd6, 16'd4}, 0, 5, 2);
        for (int i = 0; i < 3; i++) void'(script.pop_back());
        pushReset(2, 1'b1);
        buildInstr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 2, 0, 2);

        // randomized instruction stream with random handshake timing
        for (int i = 0; i < 300; i++) begin
            buildInstr(randInstr(), $urandom_range(0, 2), $urandom_range(0, 3), 2);
        end

        applyStimulus();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS control decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, waits on a variable-latency memory handshake and a multi-cycle multiplier, and drives the datapath control lines per state. It sits between the instruction register and the shared ALU, register file and unified memory of the multi-cycle datapath.

Parameters:
MUL_LATENCY, 4, cycles the multiplier needs after MulStart; legal range 1..15
ALU_CTRL_W, 5, width of ALUControl; opcode encodings come from the shared package
CNT_W, 4, width of the internal wait counter; must satisfy 2^CNT_W > MUL_LATENCY

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
Instruction  in  32  instruction register output, stable from DECODE to the end of the instruction
MemReady  in  1  memory has completed the current read or write
BranchCond  in  1  ALU branch-condition result, valid in the BRANCH state
PCWrite  out  1  load the PC
IRWrite  out  1  load the instruction register
IorD  out  1  0 selects the PC as memory address, 1 selects ALUOut
RegWrite  out  1  register file write enable
RegDst  out  1  1 selects rd, 0 selects rt
MemToReg  out  1  0 selects memory data, 1 selects ALUOut
ALUSrcA  out  1  0 selects the PC, 1 selects rs
ALUSrcB  out  2  00 selects rt, 01 selects 4, 10 selects sign-extended imm, 11 selects imm<<2
ALUControl  out  ALU_CTRL_W  ALU operation
ShiftControl  out  1  shamt replaces rs, for sll and srl
MemRead  out  2  00 none, 01 word, 10 half, 11 byte
MemWrite  out  2  same encoding as MemRead
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
Jal  out  1  write PC+4 to $31
MulStart  out  1  one-cycle multiplier start pulse
IllegalOp  out  1  one-cycle pulse on an unsupported opcode
Busy  out  1  0 only in the IDLE state

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MUL_WAIT, MEM_ADDR, MEM_ACC, WB, BRANCH, JUMP.
- Reset: Rst=0 asynchronously forces IDLE and clears the wait counter. In IDLE every output is 0.
- IDLE -> FETCH on the first clock edge after reset is released.
- FETCH: IorD=0, MemRead=01, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSource=00.
  - Stays in FETCH while MemReady=0.
  - When MemReady=1: IRWrite=1 and PCWrite=1 for exactly that cycle, then -> DECODE.
- DECODE (1 cycle): ALUSrcA=0, ALUSrcB=11, ALUControl=add, which precomputes the branch target into ALUOut. Next state by opcode:
  - R-type, mul, addi, andi, ori, xori, slti -> EXEC
  - lw, lh, lb, sw, sh, sb -> MEM_ADDR
  - beq, bne, REGIMM (bgez/bltz), bgtz, blez -> BRANCH
  - j, jal, jr -> JUMP
  - any other opcode: IllegalOp=1 for one cycle -> FETCH. The PC has already advanced.
- EXEC: ALUSrcA=1. ALUSrcB=00 for R-type and mul, 10 for immediates. ALUControl and ShiftControl use the same funct/opcode mapping as the single-cycle decoder (add 00001, sub 00010, mul 00011, sll 00100, srl 00101, and 00110, or 00111, xor 01000, nor 01101, slt 01110).
  - mul: MulStart=1, counter loads MUL_LATENCY-1, -> MUL_WAIT.
  - all other EXEC instructions -> WB.
  - An unsupported funct gives IllegalOp=1 and -> FETCH.
- MUL_WAIT: counter decrements each cycle; -> WB when the counter reaches 0. Total mul occupancy = FETCH + 1 + 1 + MUL_LATENCY + 1 cycles.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add -> MEM_ACC.
- MEM_ACC: IorD=1 with MemRead or MemWrite set to the size code. Holds until MemReady=1.
  - Loads -> WB.
  - Stores -> FETCH.
- WB: RegWrite=1. RegDst=1 for R-type and mul, otherwise 0. MemToReg=0 for loads, otherwise 1. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, branch ALUControl per opcode/rt.
  - PCSource=01, PCWrite=BranchCond.
  - -> FETCH.
- JUMP: PCWrite=1. PCSource=10 for j and jal, 11 for jr. For jal, Jal=1 and RegWrite=1. -> FETCH.
- Outputs are combinational from state and Instruction (Moore per state). Signals not listed for a state are 0.
- Reset asserted mid-instruction abandons the instruction with no further writes. MemReady arriving while the block is not in FETCH or MEM_ACC is ignored.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum
  - opcode and funct constants
  - ALUControl encodings
  - size codes for MemRead/MemWrite
  - PCSource and ALUSrcB codes
- Sub-module mc_alu_decode: purely combinational map from opcode/funct/rt to ALUControl, ShiftControl and an illegal flag. Reused by EXEC and BRANCH.

Test Plan:
- add $3,$1,$2 with MemReady tied 1 -> FETCH, DECODE, EXEC (ALUControl=00001), WB (RegWrite=1, RegDst=1); 4 cycles; PCWrite exactly once.
- lw with MemReady low 3 cycles in MEM_ACC -> MemRead=01 and IorD=1 held 4 cycles; then WB with MemToReg=0; no extra PCWrite.
- mul with MUL_LATENCY=4 -> MulStart one pulse; MUL_WAIT 4 cycles; WB on the 8th cycle.
- beq with BranchCond=1, then bne with BranchCond=0 -> PCWrite=1 with PCSource=01, then PCWrite=0; both return to FETCH.
- jr $31, then jal 0x100 -> PCSource=11, then PCSource=10 with Jal=1 and RegWrite=1.
- Opcode 6'b111111 -> IllegalOp one pulse in DECODE, -> FETCH. Rst low during MEM_ACC of sw -> IDLE immediately; all outputs 0; MemWrite never asserted after reset.
